rate_tick_ctrl: RTL and testbench

Rate controller for the board's slow/fast timebase. It owns a single programmable period counter and switches between two period settings on a select input. A requested rate change takes effect only at a period boundary, so downstream logic never sees a runt tick or a truncated `outclk` half-period. It feeds display/LED blink logic with a one-cycle `tick` strobe and a 50 % duty `outclk` square wave.

---
 rtl/rate_tick_ctrl.sv | 106 ++++++++++
 tb/tb_rate_tick_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rate_tick_ctrl.sv
// rtl/rate_tick_ctrl.sv - two-rate period counter with boundary-aligned rate switching
//
// Generates a one-cycle tick and a 50 % duty outclk from a single period
// counter whose period is SLOW_DIV or FAST_DIV clk cycles. A change on sel is
// only applied at a period boundary, so no runt tick or short outclk half.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   en          run enable; low holds the counter at 0 and outclk at its value
//   sel         requested rate (0 = slow, 1 = fast)
//   tick        one-cycle strobe following the last cycle of each period
//   outclk      toggles on every tick (period 2 x DIV)
//   active_sel  rate currently in use
//   pending     a rate change is requested but not yet applied
//
// Build option: define RATE_TICK_CTRL_SYNC_EN to pass sel through a 2-flop
// synchronizer; leave it undefined only when sel is already synchronous to clk.

module rate_tick_ctrl #(
   parameter int SLOW_DIV = 50_000_000,
   parameter int FAST_DIV = 5_000_000,
   parameter int CNT_W    = 31
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sel,
   output logic tick,
   output logic outclk,
   output logic active_sel,
   output logic pending
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

   logic             sel_s;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_last;
   logic             terminal;
   state_t           state;

`ifdef RATE_TICK_CTRL_SYNC_EN
   logic sync_q1;
   logic sync_q2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= sel;
         sync_q2 <= sync_q1;
      end
   end

   assign sel_s = sync_q2;
`else
   assign sel_s = sel;
`endif

   // The compare only ever uses the active period, and active_sel changes
   // only when cnt returns to 0, so cnt can never run past the new limit.
   assign cnt_last = active_sel ? FAST_LAST : SLOW_LAST;
   assign terminal = (cnt == cnt_last);
   assign pending  = (state == ST_PEND);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         tick       <= 1'b0;
         outclk     <= 1'b0;
         active_sel <= 1'b0;
         state      <= ST_RUN;
      end else if (!en) begin
         // Halted: no period in progress, so a new rate can be taken at once.
         cnt        <= '0;
         tick       <= 1'b0;
         active_sel <= sel_s;
         state      <= ST_RUN;
      end else if (terminal) begin
         // Period boundary: any outstanding request (or one arriving on this
         // very cycle) is applied here and the new rate starts from 0.
         cnt        <= '0;
         tick       <= 1'b1;
         outclk     <= ~outclk;
         active_sel <= sel_s;
         state      <= ST_RUN;
      end else begin
         cnt  <= cnt + CNT_W'(1);
         tick <= 1'b0;
         case (state)
            ST_RUN:  if (sel_s != active_sel) state <= ST_PEND;
            ST_PEND: if (sel_s == active_sel) state <= ST_RUN;
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_rate_tick_ctrl.sv
// tb/tb_rate_tick_ctrl.sv - directed scoreboard bench for rate_tick_ctrl

module tb_rate_tick_ctrl;

   localparam int SLOW = 10;
   localparam int FAST = 4;
`ifdef RATE_TICK_CTRL_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int   e;
      logic oc;
      logic act;
   } tick_exp_t;

   logic clk;
   logic rst_n;
   logic en;
   logic sel;
   logic tick;
   logic outclk;
   logic active_sel;
   logic pending;

   int        checks   = 0;
   int        failures = 0;
   int        edge_n   = 0;
   logic      exp_oc   = 1'b0;
   tick_exp_t q[$];

   rate_tick_ctrl #(
      .SLOW_DIV(SLOW),
      .FAST_DIV(FAST),
      .CNT_W   (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sel       (sel),
      .tick      (tick),
      .outclk    (outclk),
      .active_sel(active_sel),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected tick: absolute edge index, outclk after the toggle, active rate.
   task automatic push_tick(input int e, input logic act);
      exp_oc = ~exp_oc;
      q.push_back('{e: e, oc: exp_oc, act: act});
   endtask

   // One clock: sample 1 time unit after the edge, compare against scoreboard.
   task automatic step();
      tick_exp_t ent;
      @(posedge clk);
      #1;
      edge_n++;
      if (q.size() > 0 && q[0].e == edge_n) begin
         ent = q.pop_front();
         check("tick_present", tick, 1);
         check("tick_outclk", outclk, ent.oc);
         check("tick_active_sel", active_sel, ent.act);
      end else begin
         check("no_tick", tick, 0);
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic step_to(input int target);
      while (edge_n < target) step();
   endtask

   // sel has just been driven; pending must rise exactly LAT edges later.
   task automatic expect_pending_rise(input string tag);
      for (int i = 1; i < LAT; i++) begin
         step();
         check({tag, "_pend_early"}, pending, 0);
      end
      step();
      check({tag, "_pend_rise"}, pending, 1);
   endtask

   initial begin
      int t;
      rst_n = 1'b0;
      en    = 1'b0;
      sel   = 1'b0;

      // Reset state
      steps(3);
      check("rst_tick", tick, 0);
      check("rst_outclk", outclk, 0);
      check("rst_active_sel", active_sel, 0);
      check("rst_pending", pending, 0);

      // Slow rate: first tick 10 edges after release, then every 10
      rst_n = 1'b1;
      en    = 1'b1;
      t = edge_n;
      push_tick(t + 10, 1'b0);
      push_tick(t + 20, 1'b0);
      push_tick(t + 30, 1'b0);
      for (int i = 0; i < 30; i++) begin
         step();
         check("slow_pending", pending, 0);
         check("slow_active_sel", active_sel, 0);
      end

      // Cancelled request: sel high for 3 cycles mid-period
      t = edge_n;
      steps(2);
      sel = 1'b1;
      push_tick(t + 10, 1'b0);
      expect_pending_rise("cancel");
      steps(3 - LAT);
      sel = 1'b0;
      while (edge_n < t + 10) begin
         step();
         check("cancel_active_sel", active_sel, 0);
      end
      check("cancel_pend_low", pending, 0);

      // Pending request, then en low for 5 cycles
      t = edge_n;
      steps(2);
      sel = 1'b1;
      expect_pending_rise("halt");
      en = 1'b0;
      step();
      check("halt_active_sel", active_sel, 1);
      check("halt_pending", pending, 0);
      check("halt_outclk_held", outclk, exp_oc);
      for (int i = 0; i < 4; i++) begin
         step();
         check("halt_outclk_held", outclk, exp_oc);
      end
      en = 1'b1;
      t = edge_n;
      push_tick(t + FAST, 1'b1);
      push_tick(t + 2 * FAST, 1'b1);
      step_to(t + 2 * FAST);

      // Back to slow, applied at the next fast boundary
      t = edge_n;
      sel = 1'b0;
      push_tick(t + FAST, 1'b0);
      push_tick(t + FAST + SLOW, 1'b0);
      expect_pending_rise("to_slow");
      step_to(t + FAST + SLOW);
      check("to_slow_pend_low", pending, 0);

      // Slow to fast requested at cnt=3
      t = edge_n;
      steps(3);
      sel = 1'b1;
      push_tick(t + SLOW, 1'b1);
      push_tick(t + SLOW + FAST, 1'b1);
      push_tick(t + SLOW + 2 * FAST, 1'b1);
      expect_pending_rise("to_fast");
      step_to(t + SLOW);
      check("to_fast_pend_low", pending, 0);
      check("to_fast_active_sel", active_sel, 1);
      step_to(t + SLOW + 2 * FAST);
      check("fast_pend_low", pending, 0);

      // Reset mid-period with outclk=1, active_sel=1, cnt=2
      check("pre_rst_outclk", outclk, 1);
      check("pre_rst_active_sel", active_sel, 1);
      steps(2);
      rst_n = 1'b0;
      step();
      check("mid_rst_tick", tick, 0);
      check("mid_rst_outclk", outclk, 0);
      check("mid_rst_active_sel", active_sel, 0);
      check("mid_rst_pending", pending, 0);
      exp_oc = 1'b0;
      rst_n = 1'b1;
      t = edge_n;
      // sel is still 1: slow first period, switch to fast at its end
      push_tick(t + SLOW, 1'b1);
      push_tick(t + SLOW + FAST, 1'b1);
      expect_pending_rise("post_rst");
      check("post_rst_active_sel", active_sel, 0);
      step_to(t + SLOW + FAST + 1);
      check("scoreboard_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
